regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port integer register file with write-through bypass and a per-register busy scoreboard, succeeding the fixed 32x32 two-read/one-write register file in the single-cycle core. It sits in the decode stage of the pipelined core: NRD read ports serve operand fetch, and two write ports accept ALU writeback and late load return. The scoreboard tracks registers with an issued-but-unwritten result and produces a stall request.

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of registers; power of 2, 8..64
- NRD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1 = register 0 hardwired to zero (never written, never busy)
- AW, $clog2(NREGS), address width (derived, not overridable)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- rd_busy  out  NRD  port k operand not yet available
- stall  out  1  OR of rd_busy over ports selected by rd_use
- rd_use  in  NRD  port k operand actually consumed this cycle
- w0_en, w0_addr, w0_data  in  1/AW/XLEN  write port 0 (ALU writeback)
- w1_en, w1_addr, w1_data  in  1/AW/XLEN  write port 1 (load return)
- iss_en, iss_addr  in  1/AW  issue: mark destination register busy

## Operation
- Storage: NREGS x XLEN array plus NREGS busy bits.
- Writes at posedge: wK_en=1 writes wK_data to wK_addr and clears busy[wK_addr]. w0 and w1 to the same address in one cycle: w1 data wins; busy cleared.
- ZERO_REG=1: writes and issues to address 0 are ignored; port k reading address 0 returns 0, rd_busy[k]=0.
- Read data (combinational): if w1_en and w1_addr==rd_addr[k], return w1_data; else if w0_en and w0_addr match, return w0_data; else the array value. Zero rule overrides bypass.
- rd_busy[k] = busy[rd_addr[k]] AND NOT (a write to rd_addr[k] this cycle). A same-cycle write makes the operand valid via bypass.
- Issue: iss_en=1 sets busy[iss_addr] at posedge. Issue and write to the same address in one cycle: set wins; the register stays busy for the new producer, and the write still updates data.
- Issuing to an already-busy register is legal: busy stays 1, and the first subsequent write clears it. Ordering is the pipeline's responsibility.
- stall = OR over k of (rd_use[k] & rd_busy[k]).

## Timing
- Reset (reset_n=0, async): all registers 0, all busy 0. Consequently rd_data=0, rd_busy=0, stall=0 immediately, independent of clk. Writes and issues are ignored while reset_n=0.
- Reset deassertion mid-operation: all pending busy state is discarded. The first edge after deassertion is fully functional.
- Read latency 0 (combinational from rd_addr and write ports). Write-to-array latency 1 edge. Bypass makes a written value visible in the write cycle.
- Busy set/clear becomes visible in rd_busy one cycle after the edge at which iss_en/wK_en is sampled. The same-cycle write masking above is the only combinational path from write ports to rd_busy.
- No combinational path from rd_use to anything but stall.

## Structure
- Shared package regfile_pkg: default XLEN/NREGS constants and the ZERO address localparam.
- One sub-module: regfile_busy_sb, which holds the NREGS busy bits with set/clear priority and reset. It exposes busy vector output.
- Top holds the data array, bypass muxes (generate loop over NRD) and the stall reduction.

## Test plan
- Reset: write x5=0xDEADBEEF, assert reset_n=0 between edges -> rd_data for x5 reads 0 immediately, stall=0.
- Bypass priority: w0 x3=0x11, w1 x3=0x22 same cycle, read x3 -> rd_data=0x22 that cycle; next cycle array value is 0x22.
- Zero register: w0 x0=0xFFFF_FFFF, iss_en x0 -> read x0 gives 0, rd_busy=0, stall=0.
- Scoreboard: iss x7; next cycle read x7 with rd_use=1 -> stall=1; w1 x7=0x55 -> that cycle rd_busy=0, rd_data=0x55, stall=0.
- Issue/write collision: x9 busy, w0 x9=0xA5 and iss_en x9 same edge -> next cycle x9 reads 0xA5 with rd_busy=1.
- Params NRD=4, NREGS=64: all four ports read distinct addresses 60..63 after writes -> correct data on each slice; rd_use=0 on a busy port -> stall=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults for the decode-stage register file
package regfile_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int ZERO_ADDR = 0;
endpackage

// File: rtl/regfile_busy_sb.sv
// regfile_busy_sb: per-register busy scoreboard, issue set wins over write clear
module regfile_busy_sb
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter bit ZERO_REG = 1'b1,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             iss_en,
   input  logic [AW-1:0]    iss_addr,
   input  logic             w0_en,
   input  logic [AW-1:0]    w0_addr,
   input  logic             w1_en,
   input  logic [AW-1:0]    w1_addr,
   output logic [NREGS-1:0] busy
);
   logic [NREGS-1:0] busy_nxt;
   for (genvar i = 0; i < NREGS; i++) begin : g_bit
      assign busy_nxt[i] = (ZERO_REG && i == ZERO_ADDR) ? 1'b0 :
         (iss_en && iss_addr == AW'(i)) ||
         (busy[i] && !((w0_en && w0_addr == AW'(i)) || (w1_en && w1_addr == AW'(i))));
   end
   // busy register; reset discards every pending producer
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) busy <= '0;
      else busy <= busy_nxt;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write-through bypass and busy scoreboard
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD = 2,
   parameter bit ZERO_REG = 1'b1,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   output logic                stall,
   input  logic [NRD-1:0]      rd_use,
   input  logic                w0_en,
   input  logic [AW-1:0]       w0_addr,
   input  logic [XLEN-1:0]     w0_data,
   input  logic                w1_en,
   input  logic [AW-1:0]       w1_addr,
   input  logic [XLEN-1:0]     w1_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr
);
   logic [XLEN-1:0]  mem [NREGS];
   logic [NREGS-1:0] busy;
   logic             w0_ok, w1_ok;
   assign w0_ok = w0_en && !(ZERO_REG && w0_addr == AW'(ZERO_ADDR));
   assign w1_ok = w1_en && !(ZERO_REG && w1_addr == AW'(ZERO_ADDR));
   regfile_busy_sb #(.NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_busy (
      .clk(clk),
      .reset_n(reset_n),
      .iss_en(iss_en),
      .iss_addr(iss_addr),
      .w0_en(w0_en),
      .w0_addr(w0_addr),
      .w1_en(w1_en),
      .w1_addr(w1_addr),
      .busy(busy)
   );
   // array write; w1 is applied last so it wins a same-address collision
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else begin
         if (w0_ok) mem[w0_addr] <= w0_data;
         if (w1_ok) mem[w1_addr] <= w1_data;
      end
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] a;
      logic          h0, h1, z;
      assign a  = rd_addr[k*AW +: AW];
      // writes are ignored during reset, so they must not bypass either
      assign h0 = reset_n && w0_en && w0_addr == a;
      assign h1 = reset_n && w1_en && w1_addr == a;
      assign z  = ZERO_REG && a == AW'(ZERO_ADDR);
      assign rd_data[k*XLEN +: XLEN] = z ? '0 : h1 ? w1_data : h0 ? w0_data : mem[a];
      assign rd_busy[k] = busy[a] && !(h0 || h1);
   end
   assign stall = |(rd_use & rd_busy);
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against a behavioural model
module tb_regfile_sb;
   localparam int XLEN = 32;
   localparam int NREGS = 64;
   localparam int NRD = 4;
   localparam int AW = 6;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic [NRD*AW-1:0]   rd_addr = '0;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                stall;
   logic [NRD-1:0]      rd_use = '0;
   logic                w0_en = 1'b0, w1_en = 1'b0, iss_en = 1'b0;
   logic [AW-1:0]       w0_addr = '0, w1_addr = '0, iss_addr = '0;
   logic [XLEN-1:0]     w0_data = '0, w1_data = '0;

   int checks = 0;
   int failures = 0;

   logic [XLEN-1:0] m_mem [NREGS] = '{default: '0};
   bit              m_busy [NREGS] = '{default: 1'b0};

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .rd_busy(rd_busy),
      .stall(stall),
      .rd_use(rd_use),
      .w0_en(w0_en),
      .w0_addr(w0_addr),
      .w0_data(w0_data),
      .w1_en(w1_en),
      .w1_addr(w1_addr),
      .w1_data(w1_data),
      .iss_en(iss_en),
      .iss_addr(iss_addr)
   );

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] exp_data(int a);
      if (!reset_n || a == 0) return '0;
      if (w1_en && w1_addr == a) return w1_data;
      if (w0_en && w0_addr == a) return w0_data;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(int a);
      return reset_n && a != 0 && m_busy[a] && !(w0_en && w0_addr == a) && !(w1_en && w1_addr == a);
   endfunction

   // reference state: plain array of values and a set of pending destinations
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (w0_en && w0_addr != 0) begin
            m_mem[w0_addr] = w0_data;
            m_busy[w0_addr] = 1'b0;
         end
         if (w1_en && w1_addr != 0) begin
            m_mem[w1_addr] = w1_data;
            m_busy[w1_addr] = 1'b0;
         end
         if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      end
   end

   // every cycle: all read ports and stall against the model
   always @(negedge clk) begin
      logic es;
      es = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         chk("rd_data", rd_data[k*XLEN +: XLEN], exp_data(int'(rd_addr[k*AW +: AW])));
         chk("rd_busy", {31'b0, rd_busy[k]}, {31'b0, exp_busy(int'(rd_addr[k*AW +: AW]))});
         es |= rd_use[k] & exp_busy(int'(rd_addr[k*AW +: AW]));
      end
      chk("stall", {31'b0, stall}, {31'b0, es});
   end

   task automatic idle();
      w0_en = 1'b0;
      w1_en = 1'b0;
      iss_en = 1'b0;
      rd_use = '0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic look();
      @(negedge clk);
      #1;
   endtask

   task automatic rd(input int k, input int a);
      rd_addr[k*AW +: AW] = AW'(a);
   endtask

   function automatic logic [AW-1:0] ra();
      return ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
   endfunction

   initial begin
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      // reset: written value vanishes as soon as reset_n falls
      w0_en = 1'b1; w0_addr = 5; w0_data = 32'hDEADBEEF; rd(0, 5);
      look(); chk("x5_bypass", rd_data[31:0], 32'hDEADBEEF);
      next(); rd(0, 5);
      look(); chk("x5_array", rd_data[31:0], 32'hDEADBEEF);
      reset_n = 1'b0;
      #1 chk("reset_data", rd_data[31:0], 32'h0);
      chk("reset_stall", {31'b0, stall}, 32'h0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      look(); chk("x5_after_reset", rd_data[31:0], 32'h0);
      // bypass priority
      next(); w0_en = 1'b1; w0_addr = 3; w0_data = 32'h11; w1_en = 1'b1; w1_addr = 3; w1_data = 32'h22; rd(0, 3);
      look(); chk("bypass_w1_wins", rd_data[31:0], 32'h22);
      next();
      look(); chk("array_w1_wins", rd_data[31:0], 32'h22);
      // zero register
      next(); w0_en = 1'b1; w0_addr = 0; w0_data = 32'hFFFFFFFF; iss_en = 1'b1; iss_addr = 0; rd(0, 0); rd_use = 4'b0001;
      look(); chk("x0_data", rd_data[31:0], 32'h0);
      chk("x0_busy", {31'b0, rd_busy[0]}, 32'h0);
      chk("x0_stall", {31'b0, stall}, 32'h0);
      next(); rd_use = 4'b0001;
      look(); chk("x0_data_next", rd_data[31:0], 32'h0);
      chk("x0_busy_next", {31'b0, rd_busy[0]}, 32'h0);
      // scoreboard
      next(); iss_en = 1'b1; iss_addr = 7;
      next(); rd(0, 7); rd_use = 4'b0001;
      look(); chk("x7_stall", {31'b0, stall}, 32'h1);
      chk("x7_busy", {31'b0, rd_busy[0]}, 32'h1);
      next(); w1_en = 1'b1; w1_addr = 7; w1_data = 32'h55; rd_use = 4'b0001;
      look(); chk("x7_wr_busy", {31'b0, rd_busy[0]}, 32'h0);
      chk("x7_wr_data", rd_data[31:0], 32'h55);
      chk("x7_wr_stall", {31'b0, stall}, 32'h0);
      // issue/write collision
      next(); iss_en = 1'b1; iss_addr = 9;
      next(); w0_en = 1'b1; w0_addr = 9; w0_data = 32'hA5; iss_en = 1'b1; iss_addr = 9;
      next(); rd(0, 9);
      look(); chk("x9_data", rd_data[31:0], 32'hA5);
      chk("x9_busy", {31'b0, rd_busy[0]}, 32'h1);
      // four ports on the top addresses
      next(); w0_en = 1'b1; w0_addr = 60; w0_data = 32'h10000060; w1_en = 1'b1; w1_addr = 61; w1_data = 32'h10000061;
      next(); w0_en = 1'b1; w0_addr = 62; w0_data = 32'h10000062; w1_en = 1'b1; w1_addr = 63; w1_data = 32'h10000063;
      next(); for (int k = 0; k < NRD; k++) rd(k, 60 + k);
      look();
      for (int k = 0; k < NRD; k++) chk("port_slice", rd_data[k*XLEN +: XLEN], 32'h10000060 + k);
      next(); iss_en = 1'b1; iss_addr = 62;
      next(); rd_use = 4'b1011;
      look(); chk("p2_busy", {31'b0, rd_busy[2]}, 32'h1);
      chk("p2_unused_stall", {31'b0, stall}, 32'h0);
      rd_use = 4'b0100;
      #1 chk("p2_used_stall", {31'b0, stall}, 32'h1);
      // randomized traffic with occasional asynchronous reset pulses
      repeat (3000) begin
         @(posedge clk);
         #1;
         reset_n = 1'b1;
         w0_en = ($urandom_range(0, 9) < 4); w0_addr = ra(); w0_data = $urandom;
         w1_en = ($urandom_range(0, 9) < 3); w1_addr = ra(); w1_data = $urandom;
         iss_en = ($urandom_range(0, 9) < 4); iss_addr = ra();
         for (int k = 0; k < NRD; k++) rd(k, int'(ra()));
         rd_use = NRD'($urandom);
         if ($urandom_range(0, 99) == 0) #2 reset_n = 1'b0;
      end
      next();
      reset_n = 1'b1;
      repeat (2) next();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
